// File: rtl/pipeline_control_if.sv
// Hazard/control bundle between the ID-stage hazard detectors, the pipeline
// registers and the EX operand muxes. The slave side is the pipeline controller.
interface pipeline_control_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       haz_ex;
   logic             stall_ex;
   logic [3:0]       haz_mem;
   logic             redirect;
   logic             pc_we;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output haz_ex, stall_ex, haz_mem, redirect,
      input  pc_we, ifid_we, ifid_flush, idex_bubble,
      input  fwd_a, fwd_b, stall_cnt, flush_cnt
   );

   modport slave (
      input  haz_ex, stall_ex, haz_mem, redirect,
      output pc_we, ifid_we, ifid_flush, idex_bubble,
      output fwd_a, fwd_b, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_control.sv
// Pipeline controller: turns hazard-detector results and the EX redirect into
// register enables, bubble/flush controls and registered EX forwarding selects,
// and keeps saturating stall/flush event counters for performance debug.
module pipeline_control #(
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipeline_control_if.slave ctl
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2
   } state_t;

   localparam logic [2:0] FROM_EX_RS1  = 3'b001;
   localparam logic [2:0] FROM_EX_RS2  = 3'b010;
   localparam logic [2:0] FROM_MEM_RS1 = 3'b011;
   localparam logic [2:0] FROM_MEM_RS2 = 3'b100;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           next_state;
   logic             stall_evt;
   logic             flush_evt;
   logic             advance;
   logic [1:0]       fwd_a_next;
   logic [1:0]       fwd_b_next;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   logic       ex_valid;
   logic [2:0] ex_code;
   logic       mem_valid;
   logic [2:0] mem_code;

   assign ex_valid  = ctl.haz_ex[3];
   assign ex_code   = ctl.haz_ex[2:0];
   assign mem_valid = ctl.haz_mem[3];
   assign mem_code  = ctl.haz_mem[2:0];

   // State register; reset drops straight back to RUN from any stall or squash
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next state and Mealy controls; redirect wins over everything, stall only honoured in RUN
   always_comb begin
      next_state      = RUN;
      ctl.pc_we       = 1'b1;
      ctl.ifid_we     = 1'b1;
      ctl.ifid_flush  = 1'b0;
      ctl.idex_bubble = 1'b0;
      stall_evt       = 1'b0;
      flush_evt       = 1'b0;
      if (ctl.redirect) begin
         ctl.ifid_flush  = 1'b1;
         ctl.idex_bubble = 1'b1;
         flush_evt       = 1'b1;
         next_state      = SQUASH;
      end else if (state == RUN && ctl.stall_ex) begin
         ctl.pc_we       = 1'b0;
         ctl.ifid_we     = 1'b0;
         ctl.idex_bubble = 1'b1;
         stall_evt       = 1'b1;
         next_state      = HOLD;
      end
   end

   // Forwarding selects for the instruction about to enter EX; EX-stage data is newer so it wins
   always_comb begin
      advance    = !ctl.idex_bubble && (state != SQUASH);
      fwd_a_next = 2'b00;
      fwd_b_next = 2'b00;
      if (advance) begin
         if (ex_valid && ex_code == FROM_EX_RS1) begin
            fwd_a_next = 2'b01;
         end else if (mem_valid && mem_code == FROM_MEM_RS1) begin
            fwd_a_next = 2'b10;
         end
         if (ex_valid && ex_code == FROM_EX_RS2) begin
            fwd_b_next = 2'b01;
         end else if (mem_valid && mem_code == FROM_MEM_RS2) begin
            fwd_b_next = 2'b10;
         end
      end
   end

   // Capture the selects on the edge that moves ID into EX (zeros for a bubble or squashed slot)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a <= 2'b00;
         fwd_b <= 2'b00;
      end else begin
         fwd_a <= fwd_a_next;
         fwd_b <= fwd_b_next;
      end
   end

   // Saturating event counters for load-use bubbles and taken redirects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_evt && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end
         if (flush_evt && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end
      end
   end

   assign ctl.fwd_a     = fwd_a;
   assign ctl.fwd_b     = fwd_b;
   assign ctl.stall_cnt = stall_cnt;
   assign ctl.flush_cnt = flush_cnt;

endmodule
